// File: rtl/vram_arbiter_if.sv
// Bus bundle between the VRAM arbiter and its users: video read path, CHIP-8 core,
// clear-screen control and the single BRAM port.
interface vram_arbiter_if #(
  parameter int ADDR_WIDTH = 16
);
  logic                  video_req_in;
  logic [ADDR_WIDTH-1:0] video_addr_in;
  logic [7:0]            video_data_out;
  logic                  video_valid_out;
  logic                  cpu_req_in;
  logic                  cpu_we_in;
  logic [ADDR_WIDTH-1:0] cpu_addr_in;
  logic [7:0]            cpu_wdata_in;
  logic                  cpu_ready_out;
  logic [7:0]            cpu_rdata_out;
  logic                  cpu_rvalid_out;
  logic                  clear_start_in;
  logic                  clear_busy_out;
  logic                  clear_done_out;
  logic [ADDR_WIDTH-1:0] vram_addr_out;
  logic                  vram_we_out;
  logic [7:0]            vram_wdata_out;
  logic [7:0]            vram_rdata_in;

  modport slave (
    input  video_req_in, video_addr_in, cpu_req_in, cpu_we_in, cpu_addr_in, cpu_wdata_in,
           clear_start_in, vram_rdata_in,
    output video_data_out, video_valid_out, cpu_ready_out, cpu_rdata_out, cpu_rvalid_out,
           clear_busy_out, clear_done_out, vram_addr_out, vram_we_out, vram_wdata_out
  );

  modport master (
    output video_req_in, video_addr_in, cpu_req_in, cpu_we_in, cpu_addr_in, cpu_wdata_in,
           clear_start_in, vram_rdata_in,
    input  video_data_out, video_valid_out, cpu_ready_out, cpu_rdata_out, cpu_rvalid_out,
           clear_busy_out, clear_done_out, vram_addr_out, vram_we_out, vram_wdata_out
  );
endinterface

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: video reads > clear-screen sweep > CHIP-8 core accesses.
// Read data is steered back to its requester by a tag pipeline matching BRAM latency.
module vram_arbiter #(
  parameter int ADDR_WIDTH   = 16,
  parameter int DEPTH        = 256,
  parameter int READ_LATENCY = 2
) (
  input logic          clk_in,
  input logic          rst_in,
  vram_arbiter_if.slave bus
);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic {ST_IDLE, ST_CLEAR} state_t;
  typedef enum logic [1:0] {TAG_NONE, TAG_VIDEO, TAG_CPU} tag_t;

  state_t                state;
  logic [IDX_W-1:0]      clear_idx;
  logic                  busy_q;
  logic                  done_q;
  tag_t                  tags [READ_LATENCY];
  tag_t                  tag_new;
  tag_t                  tag_last_in;
  logic                  gnt_clear;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [ADDR_WIDTH-1:0] addr_mux;
  logic                  we_mux;
  logic                  ready_mux;
  logic [7:0]            wdata_mux;
  logic [7:0]            video_data_q;
  logic [7:0]            cpu_data_q;

  // Reset forces every combinational port output low, not just the registers.
  always_comb begin
    addr_mux  = addr_q;
    we_mux    = 1'b0;
    ready_mux = 1'b0;
    wdata_mux = '0;
    tag_new   = TAG_NONE;
    gnt_clear = 1'b0;
    if (rst_in) begin
      addr_mux = '0;
    end else if (bus.video_req_in) begin
      addr_mux = bus.video_addr_in;
      tag_new  = TAG_VIDEO;
    end else if (state == ST_CLEAR) begin
      gnt_clear = 1'b1;
      addr_mux  = ADDR_WIDTH'(clear_idx);
      we_mux    = 1'b1;
    end else if (bus.cpu_req_in) begin
      ready_mux = 1'b1;
      addr_mux  = bus.cpu_addr_in;
      we_mux    = bus.cpu_we_in;
      wdata_mux = bus.cpu_wdata_in;
      tag_new   = bus.cpu_we_in ? TAG_NONE : TAG_CPU;
    end
  end

  // Data registers load on the edge that moves a tag into the last stage.
  if (READ_LATENCY > 1) begin : g_deep
    assign tag_last_in = tags[READ_LATENCY-2];
  end else begin : g_shallow
    assign tag_last_in = tag_new;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state     <= ST_IDLE;
      clear_idx <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.clear_start_in) begin
            state     <= ST_CLEAR;
            clear_idx <= '0;
            busy_q    <= 1'b1;
          end
        end
        ST_CLEAR: begin
          if (gnt_clear) begin
            if (clear_idx == IDX_W'(DEPTH - 1)) begin
              state     <= ST_IDLE;
              clear_idx <= '0;
              busy_q    <= 1'b0;
              done_q    <= 1'b1;
            end else begin
              clear_idx <= clear_idx + 1'b1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      for (int unsigned i = 0; i < READ_LATENCY; i++) tags[i] <= TAG_NONE;
      addr_q       <= '0;
      video_data_q <= '0;
      cpu_data_q   <= '0;
    end else begin
      tags[0] <= tag_new;
      for (int unsigned i = 1; i < READ_LATENCY; i++) tags[i] <= tags[i-1];
      addr_q <= addr_mux;
      if (tag_last_in == TAG_VIDEO) video_data_q <= bus.vram_rdata_in;
      if (tag_last_in == TAG_CPU)   cpu_data_q   <= bus.vram_rdata_in;
    end
  end

  assign bus.vram_addr_out   = addr_mux;
  assign bus.vram_we_out     = we_mux;
  assign bus.vram_wdata_out  = wdata_mux;
  assign bus.cpu_ready_out   = ready_mux;
  assign bus.video_valid_out = (tags[READ_LATENCY-1] == TAG_VIDEO);
  assign bus.cpu_rvalid_out  = (tags[READ_LATENCY-1] == TAG_CPU);
  assign bus.video_data_out  = video_data_q;
  assign bus.cpu_rdata_out   = cpu_data_q;
  assign bus.clear_busy_out  = busy_q;
  assign bus.clear_done_out  = done_q;
endmodule

// File: tb/tb_vram_arbiter.sv
// Bench for vram_arbiter: BRAM model, per-cycle reference model of grants/returns/clear,
// and directed scenarios with hand-computed expectations.
module tb_vram_arbiter;
  logic clk_in = 1'b0;
  logic rst_in = 1'b1;
  always #5 clk_in = ~clk_in;

  vram_arbiter_if #(.ADDR_WIDTH(16)) bus ();

  vram_arbiter #(.ADDR_WIDTH(16), .DEPTH(256), .READ_LATENCY(2)) dut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .bus    (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // BRAM: one registered read stage, read-first; data for cycle g's address is
  // on vram_rdata_in during cycle g+1 and captured by the arbiter at edge g+2.
  logic [7:0] bram [256];
  logic [7:0] rd_q;
  always @(posedge clk_in) begin
    if (bus.vram_we_out) bram[bus.vram_addr_out[7:0]] <= bus.vram_wdata_out;
    rd_q <= bram[bus.vram_addr_out[7:0]];
  end
  assign bus.vram_rdata_in = rd_q;

  // Reference model
  typedef struct { int due; int kind; logic [7:0] data; } ret_t;
  ret_t        pend [$];
  logic [7:0]  ref_mem [256];
  int          cyc = 0;
  bit          primed = 0;
  bit          m_clear = 0;
  bit          m_done = 0;
  int          m_idx = 0;
  logic [15:0] m_last_addr = '0;
  logic [7:0]  m_vdata = '0;
  logic [7:0]  m_cdata = '0;
  bit          e_ready, e_we, e_vv, e_cv, e_clr;
  logic [15:0] e_addr;
  logic [7:0]  e_wdata;
  int          kind;

  always @(posedge clk_in) cyc++;

  always @(negedge clk_in) begin
    e_ready = 0; e_we = 0; e_wdata = '0; kind = 0; e_clr = 0;
    if (rst_in) e_addr = '0;
    else if (bus.video_req_in) begin e_addr = bus.video_addr_in; kind = 1; end
    else if (m_clear) begin e_addr = 16'(m_idx); e_we = 1; e_clr = 1; end
    else if (bus.cpu_req_in) begin
      e_ready = 1; e_addr = bus.cpu_addr_in; e_we = bus.cpu_we_in; e_wdata = bus.cpu_wdata_in;
      kind = bus.cpu_we_in ? 0 : 2;
    end else e_addr = m_last_addr;

    check("cpu_ready", 32'(bus.cpu_ready_out), 32'(e_ready));
    check("vram_we", 32'(bus.vram_we_out), 32'(e_we));
    check("vram_addr", 32'(bus.vram_addr_out), 32'(e_addr));
    if (e_we) check("vram_wdata", 32'(bus.vram_wdata_out), 32'(e_wdata));

    if (primed) begin
      e_vv = 0; e_cv = 0;
      while (pend.size() > 0 && pend[0].due == cyc) begin
        if (pend[0].kind == 1) begin e_vv = 1; m_vdata = pend[0].data; end
        else begin e_cv = 1; m_cdata = pend[0].data; end
        void'(pend.pop_front());
      end
      check("video_valid", 32'(bus.video_valid_out), 32'(e_vv));
      check("video_data", 32'(bus.video_data_out), 32'(m_vdata));
      check("cpu_rvalid", 32'(bus.cpu_rvalid_out), 32'(e_cv));
      check("cpu_rdata", 32'(bus.cpu_rdata_out), 32'(m_cdata));
      check("clear_busy", 32'(bus.clear_busy_out), 32'(m_clear));
      check("clear_done", 32'(bus.clear_done_out), 32'(m_done));
    end

    if (rst_in) begin
      pend.delete();
      m_clear = 0; m_done = 0; m_idx = 0; m_last_addr = '0;
      m_vdata = '0; m_cdata = '0; primed = 1;
    end else begin
      if (kind != 0) pend.push_back('{cyc + 2, kind, ref_mem[e_addr[7:0]]});
      if (e_we) ref_mem[e_addr[7:0]] = e_wdata;
      m_last_addr = e_addr;
      m_done = 0;
      if (!m_clear && bus.clear_start_in) begin
        m_clear = 1; m_idx = 0;
      end else if (e_clr) begin
        if (m_idx == 255) begin m_clear = 0; m_done = 1; m_idx = 0; end
        else m_idx++;
      end
    end
  end

  task automatic step();
    @(posedge clk_in); #1;
  endtask

  task automatic cpu_access(input bit we, input logic [15:0] a, input logic [7:0] d);
    bit got;
    got = 0;
    bus.cpu_req_in = 1; bus.cpu_we_in = we; bus.cpu_addr_in = a; bus.cpu_wdata_in = d;
    for (int w = 0; w < 2000 && !got; w++) begin
      @(negedge clk_in);
      if (bus.cpu_ready_out) got = 1;
      else begin @(posedge clk_in); #1; end
    end
    if (!got) begin
      checks++; errors++;
      $display("FAIL cpu_accept_timeout actual=no_ready expected=ready addr=%0h", a);
    end
    step();
    bus.cpu_req_in = 0;
  endtask

  int nbusy, ndone, nbad, nrv;
  bit fin;

  initial begin
    for (int i = 0; i < 256; i++) begin
      bram[i] = 8'(i * 7 + 3);
      ref_mem[i] = 8'(i * 7 + 3);
    end
    bus.video_req_in = 0; bus.video_addr_in = '0;
    bus.cpu_req_in = 0; bus.cpu_we_in = 0; bus.cpu_addr_in = '0; bus.cpu_wdata_in = '0;
    bus.clear_start_in = 0;
    rst_in = 1;
    step(); step();
    check("reset_busy", 32'(bus.clear_busy_out), 32'h0);
    check("reset_vvalid", 32'(bus.video_valid_out), 32'h0);
    rst_in = 0;
    step(); step();

    // Write then read back with no video traffic
    cpu_access(1, 16'h0010, 8'hA5);
    cpu_access(0, 16'h0010, 8'h00);
    check("rd_lat1_rvalid", 32'(bus.cpu_rvalid_out), 32'h0);
    step();
    check("rd_lat2_rvalid", 32'(bus.cpu_rvalid_out), 32'h1);
    check("rd_lat2_rdata", 32'(bus.cpu_rdata_out), 32'hA5);

    cpu_access(1, 16'h0005, 8'h3C);
    cpu_access(1, 16'h0006, 8'hC3);
    cpu_access(1, 16'h0020, 8'h77);
    cpu_access(1, 16'h1234, 8'h5E);

    // Video and CPU contending for three cycles
    bus.video_req_in = 1; bus.video_addr_in = 16'h0021;
    bus.cpu_req_in = 1; bus.cpu_we_in = 0; bus.cpu_addr_in = 16'h0020;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_in);
      check("contend_ready", 32'(bus.cpu_ready_out), 32'h0);
      step();
    end
    bus.video_req_in = 0;
    @(negedge clk_in);
    check("contend_accept", 32'(bus.cpu_ready_out), 32'h1);
    step();
    bus.cpu_req_in = 0;
    step();
    check("contend_rvalid", 32'(bus.cpu_rvalid_out), 32'h1);
    check("contend_rdata", 32'(bus.cpu_rdata_out), 32'h77);

    // Interleaved video then CPU reads
    bus.video_req_in = 1; bus.video_addr_in = 16'h0005;
    step();
    bus.video_req_in = 0;
    bus.cpu_req_in = 1; bus.cpu_we_in = 0; bus.cpu_addr_in = 16'h0006;
    @(negedge clk_in);
    check("ilv_ready", 32'(bus.cpu_ready_out), 32'h1);
    step();
    bus.cpu_req_in = 0;
    check("ilv_vvalid", 32'(bus.video_valid_out), 32'h1);
    check("ilv_vdata", 32'(bus.video_data_out), 32'h3C);
    check("ilv_cvalid0", 32'(bus.cpu_rvalid_out), 32'h0);
    step();
    check("ilv_cvalid", 32'(bus.cpu_rvalid_out), 32'h1);
    check("ilv_cdata", 32'(bus.cpu_rdata_out), 32'hC3);
    check("ilv_vvalid0", 32'(bus.video_valid_out), 32'h0);
    step();

    // Clear sweep with no video
    bus.clear_start_in = 1;
    nbusy = 0; ndone = 0;
    for (int i = 0; i < 270; i++) begin
      step();
      bus.clear_start_in = 0;
      nbusy += int'(bus.clear_busy_out);
      ndone += int'(bus.clear_done_out);
    end
    check("clr_busy_cycles", 32'(nbusy), 32'd256);
    check("clr_done_pulses", 32'(ndone), 32'd1);
    cpu_access(0, 16'h0010, 8'h00);
    step();
    check("clr_readback", 32'(bus.cpu_rdata_out), 32'h00);

    // Clear with video every 4th cycle and a CPU read held throughout
    cpu_access(1, 16'h0010, 8'h11);
    bus.clear_start_in = 1;
    step();
    bus.clear_start_in = 0;
    nbusy = 0; nbad = 0; fin = 0;
    for (int k = 0; k < 700 && !fin; k++) begin
      if (k > 0) step();
      if (bus.clear_done_out) fin = 1;
      else begin
        nbusy += int'(bus.clear_busy_out);
        bus.video_req_in = (k % 4 == 0);
        bus.video_addr_in = 16'(k);
        bus.cpu_req_in = 1; bus.cpu_we_in = 0; bus.cpu_addr_in = 16'h0030;
        #1;
        if (bus.clear_busy_out && bus.cpu_ready_out) nbad++;
      end
    end
    if (!fin) begin
      checks++; errors++;
      $display("FAIL sweep_timeout actual=no_done expected=done");
    end
    bus.video_req_in = 0;
    check("sweep_cycles", 32'(nbusy), 32'd342);
    check("sweep_ready_blocked", 32'(nbad), 32'd0);
    @(negedge clk_in);
    check("post_clear_ready", 32'(bus.cpu_ready_out), 32'h1);
    step();
    bus.cpu_req_in = 0;
    step();
    check("post_clear_rdata", 32'(bus.cpu_rdata_out), 32'h00);

    // Reset with a CPU read tag in flight, right after clear start
    cpu_access(1, 16'h0040, 8'h99);
    bus.clear_start_in = 1;
    bus.cpu_req_in = 1; bus.cpu_we_in = 0; bus.cpu_addr_in = 16'h0040;
    @(negedge clk_in);
    check("start_cpu_ready", 32'(bus.cpu_ready_out), 32'h1);
    step();
    bus.clear_start_in = 0; bus.cpu_req_in = 0;
    rst_in = 1;
    step();
    rst_in = 0;
    nrv = 0; ndone = 0;
    for (int i = 0; i < 6; i++) begin
      nrv += int'(bus.cpu_rvalid_out);
      ndone += int'(bus.clear_done_out);
      step();
    end
    check("abort_rvalid", 32'(nrv), 32'd0);
    check("abort_done", 32'(ndone), 32'd0);

    // Reset mid-sweep at clear_idx 100, then restart from 0
    bus.clear_start_in = 1;
    step();
    bus.clear_start_in = 0;
    for (int i = 0; i < 100; i++) step();
    check("mid_addr", 32'(bus.vram_addr_out), 32'd100);
    check("mid_we", 32'(bus.vram_we_out), 32'h1);
    rst_in = 1;
    step();
    rst_in = 0;
    ndone = 0;
    for (int i = 0; i < 5; i++) begin
      ndone += int'(bus.clear_done_out);
      step();
    end
    check("mid_abort_done", 32'(ndone), 32'd0);
    check("mid_abort_busy", 32'(bus.clear_busy_out), 32'h0);
    bus.clear_start_in = 1;
    step();
    bus.clear_start_in = 0;
    #1;
    check("restart_addr", 32'(bus.vram_addr_out), 32'd0);
    check("restart_we", 32'(bus.vram_we_out), 32'h1);
    for (int i = 0; i < 262; i++) step();
    cpu_access(0, 16'h0040, 8'h00);
    step();
    check("restart_readback", 32'(bus.cpu_rdata_out), 32'h00);

    step(); step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
